// File: rtl/lz77_encoder.sv
// Streaming LZ77 compressor: fills a lookahead, scans history one candidate per cycle, emits (pos,len,char).
// Optional macro LZ77_EARLY_EXIT_EN ends the scan once the longest possible match is found.
module lz77_encoder #(
  parameter int SEARCH_DEPTH = 30,
  parameter int LOOKAHEAD    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] code_pos,
  output logic [4:0] code_len,
  output logic [7:0] char_nxt,
  output logic       finish
);

  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hist_q [SEARCH_DEPTH];
  logic [7:0]  hist_d [SEARCH_DEPTH];
  logic [7:0]  la_q [LOOKAHEAD];
  logic [7:0]  la_d [LOOKAHEAD];
  logic [5:0]  histCnt_q, histCnt_d;
  logic [5:0]  avail_q, avail_d;
  logic        dollarSeen_q, dollarSeen_d;
  logic        started_q;
  logic [4:0]  pos_q, pos_d;
  logic [4:0]  bestLen_q, bestLen_d;
  logic [4:0]  bestPos_q, bestPos_d;
  logic [4:0]  codePos_q, codePos_d;
  logic [4:0]  codeLen_q, codeLen_d;
  logic [7:0]  charNxt_q, charNxt_d;
  logic [4:0]  shiftCnt_q, shiftCnt_d;

  logic [4:0]  candLen;
  logic [4:0]  curLen;
  logic [4:0]  curPos;
  logic        searchEnd;

  // Match length of candidate pos_q; lookahead chars past the history edge compare against LA itself (overlap).
  always_comb begin
    logic       run;
    logic [7:0] refChar;
    candLen = '0;
    run     = 1'b1;
    refChar = '0;
    for (int k = 0; k < LOOKAHEAD; k++) begin
      if (5'(k) <= pos_q) refChar = hist_q[pos_q - 5'(k)];
      else                refChar = la_q[5'(k) - pos_q - 5'd1];
      if (run && (k + 1 < int'(avail_q)) && (refChar == la_q[5'(k)])) candLen = 5'(k + 1);
      else run = 1'b0;
    end
    if ({1'b0, pos_q} >= histCnt_q) candLen = '0;
  end

  always_comb begin
    curLen = bestLen_q;
    curPos = bestPos_q;
    if (candLen > bestLen_q) begin
      curLen = candLen;
      curPos = pos_q;
    end
    searchEnd = (histCnt_q == 6'd0) || (pos_q == 5'(SEARCH_DEPTH - 1));
`ifdef LZ77_EARLY_EXIT_EN
    if ({1'b0, curLen} == avail_q - 6'd1) searchEnd = 1'b1;
`endif
  end

  assign in_ready  = (state_q == FILL) && started_q && (avail_q < 6'(LOOKAHEAD)) && !dollarSeen_q;
  assign out_valid = (state_q == EMIT);
  assign finish    = (state_q == DONE);
  assign code_pos  = codePos_q;
  assign code_len  = codeLen_q;
  assign char_nxt  = charNxt_q;

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    la_d         = la_q;
    histCnt_d    = histCnt_q;
    avail_d      = avail_q;
    dollarSeen_d = dollarSeen_q;
    pos_d        = pos_q;
    bestLen_d    = bestLen_q;
    bestPos_d    = bestPos_q;
    codePos_d    = codePos_q;
    codeLen_d    = codeLen_q;
    charNxt_d    = charNxt_q;
    shiftCnt_d   = shiftCnt_q;
    unique case (state_q)
      FILL: begin
        pos_d     = '0;
        bestLen_d = '0;
        bestPos_d = '0;
        if (in_valid && in_ready) begin
          la_d[avail_q[4:0]] = in_char;
          avail_d = avail_q + 6'd1;
          if (in_char == 8'h24) dollarSeen_d = 1'b1;
        end
        if ((avail_q == 6'(LOOKAHEAD)) || dollarSeen_q) state_d = SEARCH;
      end
      SEARCH: begin
        bestLen_d = curLen;
        bestPos_d = curPos;
        pos_d     = pos_q + 5'd1;
        if (searchEnd) begin
          state_d   = EMIT;
          codePos_d = curPos;
          codeLen_d = curLen;
          charNxt_d = la_q[curLen];
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (charNxt_q == 8'h24) begin
            state_d   = DONE;
            codePos_d = '0;
            codeLen_d = '0;
            charNxt_d = '0;
          end else begin
            state_d    = SHIFT;
            shiftCnt_d = codeLen_q;
          end
        end
      end
      SHIFT: begin
        hist_d[0] = la_q[0];
        for (int i = 1; i < SEARCH_DEPTH; i++) hist_d[i] = hist_q[i-1];
        for (int i = 0; i < LOOKAHEAD - 1; i++) la_d[i] = la_q[i+1];
        la_d[LOOKAHEAD-1] = '0;
        avail_d = avail_q - 6'd1;
        if (histCnt_q != 6'(SEARCH_DEPTH)) histCnt_d = histCnt_q + 6'd1;
        if (shiftCnt_q == 5'd0) state_d = FILL;
        else shiftCnt_d = shiftCnt_q - 5'd1;
      end
      DONE: begin
      end
      default: state_d = FILL;
    endcase
  end

  // started_q holds in_ready low during the first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      hist_q       <= '{default: '0};
      la_q         <= '{default: '0};
      histCnt_q    <= '0;
      avail_q      <= '0;
      dollarSeen_q <= 1'b0;
      started_q    <= 1'b0;
      pos_q        <= '0;
      bestLen_q    <= '0;
      bestPos_q    <= '0;
      codePos_q    <= '0;
      codeLen_q    <= '0;
      charNxt_q    <= '0;
      shiftCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      la_q         <= la_d;
      histCnt_q    <= histCnt_d;
      avail_q      <= avail_d;
      dollarSeen_q <= dollarSeen_d;
      started_q    <= 1'b1;
      pos_q        <= pos_d;
      bestLen_q    <= bestLen_d;
      bestPos_q    <= bestPos_d;
      codePos_q    <= codePos_d;
      codeLen_q    <= codeLen_d;
      charNxt_q    <= charNxt_d;
      shiftCnt_q   <= shiftCnt_d;
    end
  end

endmodule

// File: doc/lz77_encoder.md
# lz77_encoder

Streaming LZ77 compressor that sits directly upstream of the LZ77 decoder. It accepts a character string terminated by `8'h24` ('$') and emits one `(code_pos, code_len, char_nxt)` triple per match. The triple format is exactly what the decoder consumes: copy `code_len` characters from search-buffer index `code_pos`, then emit `char_nxt`. The search is sequential, one candidate position per cycle, to keep area small.

## Interface
- `SEARCH_DEPTH`, 30: history characters kept; must be ≤32.
- `LOOKAHEAD`, 25: lookahead buffer depth; must be ≤32. Maximum `code_len` is `LOOKAHEAD-1`.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  `in_char` holds a valid character.
- `in_ready`  out  1  encoder accepts `in_char` this cycle.
- `in_char`  in  8  input character.
- `out_valid`  out  1  triple on outputs is valid.
- `out_ready`  in  1  downstream accepts the triple.
- `code_pos`  out  5  match offset; index 0 = most recent history char (distance `code_pos+1`).
- `code_len`  out  5  match length, 0..`LOOKAHEAD-1`.
- `char_nxt`  out  8  literal following the match.
- `finish`  out  1  high once the triple carrying '$' has been accepted.

## Operation
- History `H[0..SEARCH_DEPTH-1]`: `H[0]` is the newest char. `hist_cnt` saturates at `SEARCH_DEPTH`.
- Lookahead `LA[0..LOOKAHEAD-1]`: `LA[0]` is the next char to encode. `avail` counts the chars it holds.
- Match rule for candidate `p` (distance `d=p+1`), valid only when `p < hist_cnt`:
  - length is the largest `n ≤ avail-1` such that `LA[k] == X(k-d)` for all `k<n`;
  - `X(j)=H[-j-1]` for `j<0`, and `X(j)=LA[j]` for `j≥0`, so overlapping matches are allowed.
- Best match is the largest `n`. Ties go to the smallest `p`. If `n=0`, then `code_pos=0`.
- `char_nxt = LA[n]`. The `n ≤ avail-1` cap guarantees this literal exists and that '$' is never inside a match.
- FSM states:
  - FILL: `in_ready=1` while `avail<LOOKAHEAD` and '$' has not yet been accepted. Exits to SEARCH the cycle after `avail` reaches `LOOKAHEAD` or '$' is accepted.
  - SEARCH: evaluates `p=0,1,…` one per cycle through `SEARCH_DEPTH-1`, keeping the best match. Goes directly to EMIT when `hist_cnt=0`.
  - EMIT: `out_valid=1`; outputs are registered and held stable until `out_ready`. On handshake, go to SHIFT, or to DONE if `char_nxt==8'h24`.
  - SHIFT: `n+1` cycles. Each cycle moves `LA[0]` into `H[0]`, shifts both buffers, decrements `avail`, and increments `hist_cnt` (saturating). Then go to FILL.
  - DONE: `finish=1`, all other outputs idle, `in_ready=0`. The block remains in DONE until reset.
- `in_valid` is ignored outside FILL. Characters after '$' are never accepted.

## Timing
- Reset values:
  - `in_ready=0`, `out_valid=0`, `code_pos=0`, `code_len=0`, `char_nxt=0`, `finish=0`;
  - buffers zeroed, `hist_cnt=0`, `avail=0`, state FILL (`in_ready` rises the first cycle after reset deasserts).
- Fill rate: 1 char/cycle.
- SEARCH latency is `SEARCH_DEPTH` cycles when `hist_cnt>0`, subject to the configuration option below.
- Triple output latency: `out_valid` rises the cycle after SEARCH ends.
- `finish` rises the cycle after the '$' triple handshake.
- Reset mid-operation, in any state: the block returns to the reset values immediately. Partial strings and history are discarded.

## Configuration
- `LZ77_EARLY_EXIT_EN`:
  - Defined: SEARCH ends as soon as the best length equals `avail-1`. Because ties favour the smallest `p`, triples are identical to the undefined case; only latency shrinks.
  - Undefined: every candidate position is always scanned.

## Test plan
- Input "a$": triples (0,0,'a') then (0,0,'$'); `finish=1` one cycle after the second handshake.
- Input "aaaaa$" (overlap): (0,0,'a') then (0,4,'$').
- Input "abcabc$": (0,0,'a'), (0,0,'b'), (0,0,'c'), (2,3,'$').
- 40×'x' then '$': (0,0,'x'), (0,24,'x'), (0,14,'$').
  - With `LZ77_EARLY_EXIT_EN`, the second and third SEARCH phases each last 1 cycle; without it, 30 cycles.
- Backpressure: hold `out_ready=0` for 10 cycles during EMIT. Outputs stay constant, `in_ready=0`, and no character is lost.
- Reset during SEARCH of "abcabc$": all outputs return to 0. A following "a$" yields exactly the test-1 triples, with no history carried over.
